// File: rtl/msdf_ram_sequencer.sv
// msdf_ram_sequencer: batch controller for the RAM arith port feeding a fixed-latency multiplier
// Optional build macro MSDF_SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter on cycle_count.
// Ports:
//   ram_clock, reset           sole clock (rising edge), asynchronous active-high reset
//   start, num_ops             batch request (sampled in IDLE) and operation count
//   x_base, y_base, z_base     operand X, operand Y and result base addresses
//   busy, done                 batch in progress, one-cycle end-of-batch pulse
//   addr_arith, data_arith,
//   we_arith, q_arith          RAM arith port (q_arith registered, valid 1 cycle after address)
//   op_x, op_y, op_valid, res  arithmetic unit operands, issue strobe and result
//   cycle_count                busy-cycle count of the last batch (0 when the counter is not built)
module msdf_ram_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 11,
  parameter int ARITH_LATENCY = 8
) (
  input  logic                  ram_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_ops,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] y_base,
  input  logic [ADDR_WIDTH-1:0] z_base,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_arith,
  output logic [DATA_WIDTH-1:0] data_arith,
  output logic                  we_arith,
  input  logic [DATA_WIDTH-1:0] q_arith,
  output logic [DATA_WIDTH-1:0] op_x,
  output logic [DATA_WIDTH-1:0] op_y,
  output logic                  op_valid,
  input  logic [DATA_WIDTH-1:0] res,
  output logic [31:0]           cycle_count
);
  localparam int CW = $clog2(ARITH_LATENCY + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(ARITH_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, RDX, RDY, LATY, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] n, xb, yb, zb, i, i_nx;
  logic [CW-1:0] wcnt;
  assign i_nx = i + 1'b1;
  always_ff @(posedge ram_clock or posedge reset)
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      xb         <= '0;
      yb         <= '0;
      zb         <= '0;
      i          <= '0;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_arith <= '0;
      data_arith <= '0;
      we_arith   <= 1'b0;
      op_x       <= '0;
      op_y       <= '0;
      op_valid   <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      we_arith <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n  <= num_ops;
          xb <= x_base;
          yb <= y_base;
          zb <= z_base;
          i  <= '0;
          if (num_ops == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= RDX;
            busy       <= 1'b1;
            addr_arith <= x_base;
          end
        end
        RDX: begin
          state      <= RDY;
          addr_arith <= yb + i;
        end
        RDY: begin
          state <= LATY;
          op_x  <= q_arith;
        end
        LATY: begin
          state    <= ISSUE;
          op_y     <= q_arith;
          op_valid <= 1'b1;
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= LAT_M1;
        end
        // res is only trusted on the last WAIT cycle, ARITH_LATENCY cycles after issue
        WAIT: if (wcnt == '0) begin
          state      <= WRITE;
          data_arith <= res;
          we_arith   <= 1'b1;
          addr_arith <= zb + i;
        end else begin
          wcnt <= wcnt - 1'b1;
        end
        WRITE: begin
          i <= i_nx;
          if (i_nx == n) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= RDX;
            addr_arith <= xb + i_nx;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef MSDF_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge ram_clock or posedge reset)
    if (reset) cycle_count <= '0;
    else if (state == IDLE && start) cycle_count <= '0;
    else if (busy && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_msdf_ram_sequencer.sv
// tb_msdf_ram_sequencer: randomized self-checking bench with RAM, multiplier and batch reference model
module tb_msdf_ram_sequencer;
  localparam int DW = 32, AW = 11, LAT = 8, P = 5 + LAT;
`ifdef MSDF_SEQ_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif
  logic ram_clock = 0, reset = 0, start = 0;
  logic [AW-1:0] num_ops = 0, x_base = 0, y_base = 0, z_base = 0;
  logic busy, done, we_arith, op_valid;
  logic [AW-1:0] addr_arith;
  logic [DW-1:0] data_arith, q_arith, op_x, op_y, res;
  logic [31:0] cycle_count;
  logic ld_en = 0;
  logic [AW-1:0] ld_a = 0;
  logic [DW-1:0] ld_d = 0;
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] mmem [2**AW];
  logic pv [LAT];
  logic [DW-1:0] pp [LAT];
  logic [AW-1:0] wq [$];
  int total = 0, bad = 0;
  bit run = 0;
  bit m_act = 0;
  int m_c = 0, m_n = 0, m_last = 0;
  logic [AW-1:0] m_x = 0, m_y = 0, m_z = 0;
  int ck, co;
  bit cin;

  msdf_ram_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARITH_LATENCY(LAT)) dut (
    .ram_clock(ram_clock), .reset(reset), .start(start), .num_ops(num_ops),
    .x_base(x_base), .y_base(y_base), .z_base(z_base), .busy(busy), .done(done),
    .addr_arith(addr_arith), .data_arith(data_arith), .we_arith(we_arith), .q_arith(q_arith),
    .op_x(op_x), .op_y(op_y), .op_valid(op_valid), .res(res), .cycle_count(cycle_count));

  always #5 ram_clock = ~ram_clock;

  function automatic logic [AW-1:0] wa(input logic [AW-1:0] b, input int k);
    return b + AW'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // RAM with registered read, and a multiplier that only shows the product LAT cycles after issue
  always @(posedge ram_clock) begin
    q_arith <= ram[addr_arith];
    if (ld_en) ram[ld_a] <= ld_d;
    else if (we_arith) ram[addr_arith] <= data_arith;
    pv[0] <= op_valid;
    pp[0] <= op_x * op_y;
    for (int j = 1; j < LAT; j++) begin
      pv[j] <= pv[j-1];
      pp[j] <= pp[j-1];
    end
  end
  assign res = pv[LAT-1] ? pp[LAT-1] : 32'hDEADBEEF;

  // Batch model: cycle c (1-based after the start edge) of n*P busy cycles, then one done cycle
  always @(posedge ram_clock or posedge reset)
    if (reset) begin
      m_act  <= 0;
      m_last <= 0;
    end else begin
      if (ld_en) mmem[ld_a] <= ld_d;
      if (m_act) begin
        if (m_c == m_n * P + 1) begin
          m_act  <= 0;
          m_last <= m_n * P;
        end else m_c <= m_c + 1;
        if (m_c <= m_n * P && (m_c - 1) % P == P - 1)
          mmem[wa(m_z, (m_c - 1) / P)] <= mmem[wa(m_x, (m_c - 1) / P)] * mmem[wa(m_y, (m_c - 1) / P)];
      end else if (start) begin
        m_act  <= 1;
        m_c    <= 1;
        m_n    <= int'(num_ops);
        m_x    <= x_base;
        m_y    <= y_base;
        m_z    <= z_base;
        m_last <= 0;
      end
    end

  always @(negedge ram_clock)
    if (run && !reset) begin
      if (m_act) begin
        ck  = (m_c - 1) / P;
        co  = (m_c - 1) % P;
        cin = m_c <= m_n * P;
        chk("busy", 32'(busy), 32'(cin));
        chk("done", 32'(done), 32'(m_c == m_n * P + 1));
        chk("we_arith", 32'(we_arith), 32'(cin && co == P - 1));
        chk("op_valid", 32'(op_valid), 32'(cin && co == 3));
        chk("cycle_count_live", cycle_count, CC_EN ? 32'(m_c - 1) : 32'd0);
        if (cin && co == 0) chk("addr_x", 32'(addr_arith), 32'(wa(m_x, ck)));
        if (cin && co == 1) chk("addr_y", 32'(addr_arith), 32'(wa(m_y, ck)));
        if (cin && co == 3) begin
          chk("op_x", op_x, mmem[wa(m_x, ck)]);
          chk("op_y", op_y, mmem[wa(m_y, ck)]);
        end
        if (cin && co == P - 1) begin
          chk("addr_z", 32'(addr_arith), 32'(wa(m_z, ck)));
          chk("data_z", data_arith, mmem[wa(m_x, ck)] * mmem[wa(m_y, ck)]);
        end
      end else begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_we", 32'(we_arith), 0);
        chk("idle_op_valid", 32'(op_valid), 0);
        chk("cycle_count_hold", cycle_count, CC_EN ? 32'(m_last) : 32'd0);
      end
    end

  task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1; ld_a = a; ld_d = d;
    @(negedge ram_clock);
    ld_en = 0;
  endtask

  task automatic go(input logic [AW-1:0] xb, yb, zb, n);
    start = 1; x_base = xb; y_base = yb; z_base = zb; num_ops = n;
    @(negedge ram_clock);
    start = 0;
  endtask

  task automatic wait_done(output int bn, output int dn);
    bit seen;
    bn = 0; dn = 0; seen = 0;
    wq.delete();
    for (int t = 0; t < 20000 && !seen; t++) begin
      if (busy) bn++;
      if (we_arith) wq.push_back(addr_arith);
      if (done) begin
        dn++;
        seen = 1;
      end else @(negedge ram_clock);
    end
    chk("done_timeout", 32'(seen), 1);
    repeat (3) begin
      @(negedge ram_clock);
      if (done) dn++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_addr"}, 32'(addr_arith), 0);
    chk({tag, "_data"}, data_arith, 0);
    chk({tag, "_we"}, 32'(we_arith), 0);
    chk({tag, "_op_x"}, op_x, 0);
    chk({tag, "_op_y"}, op_y, 0);
    chk({tag, "_op_valid"}, 32'(op_valid), 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  initial begin
    int bn, dn, n;
    logic [AW-1:0] xb, yb, zb;
    #1 reset = 1;
    @(negedge ram_clock);
    @(negedge ram_clock);
    check_zero("reset");
    reset = 0;
    run = 1;
    @(negedge ram_clock);
    for (int k = 0; k < 4; k++) begin
      ld(AW'(k), 32'(k + 1));
      ld(AW'(16 + k), 32'(k + 5));
    end
    go(0, 16, 32, 4);
    wait_done(bn, dn);
    chk("basic_z0", ram[32], 5);
    chk("basic_z1", ram[33], 12);
    chk("basic_z2", ram[34], 21);
    chk("basic_z3", ram[35], 32);
    chk("basic_busy_cycles", 32'(bn), 52);
    chk("basic_done_pulses", 32'(dn), 1);
    chk("basic_cycle_count", cycle_count, CC_EN ? 32'd52 : 32'd0);
    go(0, 16, 40, 0);
    chk("empty_done_next_cycle", 32'(done), 1);
    wait_done(bn, dn);
    chk("empty_busy_cycles", 32'(bn), 0);
    chk("empty_done_pulses", 32'(dn), 1);
    chk("empty_cycle_count", cycle_count, 0);
    for (int k = 0; k < 3; k++) begin
      ld(AW'(100 + k), 32'(k + 2));
      ld(AW'(200 + k), 32'(k + 3));
    end
    go(100, 200, 2046, 3);
    wait_done(bn, dn);
    chk("wrap_count", 32'(wq.size()), 3);
    chk("wrap_addr0", 32'(wq[0]), 2046);
    chk("wrap_addr1", 32'(wq[1]), 2047);
    chk("wrap_addr2", 32'(wq[2]), 0);
    chk("wrap_data2", ram[0], 20);
    for (int k = 0; k < 3; k++) begin
      ld(AW'(300 + k), 32'(k + 3));
      ld(AW'(310 + k), 32'(k + 7));
    end
    ld(500, 32'h1234);
    go(300, 310, 320, 3);
    repeat (P + 5) @(negedge ram_clock);
    start = 1; x_base = 0; y_base = 0; z_base = 500; num_ops = 5;
    @(negedge ram_clock);
    start = 0;
    wait_done(bn, dn);
    chk("ignored_z0", ram[320], 21);
    chk("ignored_z1", ram[321], 32);
    chk("ignored_z2", ram[322], 45);
    chk("ignored_untouched", ram[500], 32'h1234);
    chk("ignored_done_pulses", 32'(dn), 1);
    chk("ignored_cycle_count", cycle_count, CC_EN ? 32'd39 : 32'd0);
    for (int k = 0; k < 3; k++) begin
      ld(AW'(600 + k), 32'(k + 2));
      ld(AW'(610 + k), 32'(k + 10));
    end
    ld(622, 32'h5555);
    go(600, 610, 620, 3);
    repeat (2 * P + 5) @(negedge ram_clock);
    #2 reset = 1;
    #1 check_zero("midrst");
    @(negedge ram_clock);
    reset = 0;
    @(negedge ram_clock);
    chk("midrst_z0", ram[620], 20);
    chk("midrst_z1", ram[621], 33);
    chk("midrst_no_write", ram[622], 32'h5555);
    go(600, 610, 700, 3);
    wait_done(bn, dn);
    chk("fresh_z2", ram[702], 48);
    chk("fresh_done_pulses", 32'(dn), 1);
    repeat (8) begin
      n  = int'($urandom_range(0, 6));
      xb = AW'($urandom_range(0, 2047));
      yb = AW'($urandom_range(0, 2047));
      zb = AW'($urandom_range(0, 2047));
      for (int k = 0; k < n; k++) begin
        ld(wa(xb, k), $urandom);
        ld(wa(yb, k), $urandom);
      end
      go(xb, yb, zb, AW'(n));
      wait_done(bn, dn);
      chk("rand_busy_cycles", 32'(bn), 32'(n * P));
      chk("rand_done_pulses", 32'(dn), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
